// File: rtl/pet2001ps2kbd_pkg.sv
// PET 2001 PS/2 keyboard: shared codes, matrix size, decoder states
// and the scan-code to PET matrix lookup table.
package pet2001ps2kbd_pkg;

  localparam logic [7:0] PS2_E0  = 8'hE0;
  localparam logic [7:0] PS2_F0  = 8'hF0;
  localparam logic [7:0] PS2_E1  = 8'hE1;
  localparam logic [7:0] PS2_AA  = 8'hAA;
  localparam logic [7:0] PS2_FA  = 8'hFA;
  localparam logic [7:0] PS2_EE  = 8'hEE;
  localparam logic [7:0] PS2_FE  = 8'hFE;
  localparam logic [7:0] PS2_F12 = 8'h07;

  localparam int PET_ROWS = 10;
  localparam int PET_COLS = 8;

  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } dec_st_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_t;

  function automatic logic is_ignored(input logic [7:0] c);
    return c inside {PS2_AA, PS2_FA, PS2_EE, PS2_FE, 8'h00, 8'hFF};
  endfunction

  function automatic key_t key_lookup(
    input logic       ext,
    input logic [7:0] code
  );
    key_t k;
    unique case ({ext, code})
      9'h01C:  k = {1'b1, 4'd4, 3'd0};
      9'h01B:  k = {1'b1, 4'd5, 3'd0};
      9'h023:  k = {1'b1, 4'd4, 3'd1};
      9'h015:  k = {1'b1, 4'd2, 3'd0};
      9'h01D:  k = {1'b1, 4'd3, 3'd0};
      9'h016:  k = {1'b1, 4'd0, 3'd0};
      9'h05A:  k = {1'b1, 4'd6, 3'd5};
      9'h012:  k = {1'b1, 4'd8, 3'd0};
      9'h059:  k = {1'b1, 4'd8, 3'd5};
      9'h029:  k = {1'b1, 4'd9, 3'd2};
      9'h076:  k = {1'b1, 4'd9, 3'd4};
      9'h066:  k = {1'b1, 4'd1, 3'd6};
      // up and down both land on the single PET cursor-down key
      9'h175:  k = {1'b1, 4'd1, 3'd7};
      9'h172:  k = {1'b1, 4'd1, 3'd7};
      9'h16B:  k = {1'b1, 4'd0, 3'd7};
      9'h174:  k = {1'b1, 4'd0, 3'd7};
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pet2001ps2kbd_rx.sv
// PS/2 frame receiver: pin sync, falling-edge sampling, odd parity
// and framing checks, idle timeout for abandoned frames.
module pet2001ps2kbd_rx #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  logic [1:0]  r_clk_s;
  logic [1:0]  r_dat_s;
  logic        r_clk_prev;
  logic [3:0]  r_cnt;
  logic [9:0]  r_sh;
  logic [15:0] r_to;
  logic [7:0]  r_byte;
  logic        r_bv;
  logic        r_err;
  logic        w_fall;
  logic        w_good;

  assign w_fall = r_clk_prev & ~r_clk_s[1];

  // r_sh holds start..parity once ten bits are in; r_dat_s[1] is stop
  assign w_good = ~r_sh[0] & r_dat_s[1] & (^r_sh[9:1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_prev <= 1'b1;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_to       <= '0;
      r_byte     <= '0;
      r_bv       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_s    <= {r_clk_s[0], ps2_clk};
      r_dat_s    <= {r_dat_s[0], ps2_data};
      r_clk_prev <= r_clk_s[1];
      r_bv       <= 1'b0;
      r_err      <= 1'b0;
      if (w_fall) begin
        r_to <= '0;
        if (r_cnt == 4'd10) begin
          r_cnt <= '0;
          if (w_good) begin
            r_byte <= r_sh[8:1];
            r_bv   <= 1'b1;
          end else begin
            r_err  <= 1'b1;
          end
        end else begin
          r_sh  <= {r_dat_s[1], r_sh[9:1]};
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (r_cnt != '0) begin
        if (r_to == TIMEOUT) begin
          r_cnt <= '0;
          r_to  <= '0;
        end else begin
          r_to  <= r_to + 16'd1;
        end
      end else begin
        r_to <= '0;
      end
    end
  end

  assign rx_byte    = r_byte;
  assign byte_valid = r_bv;
  assign frame_err  = r_err;

endmodule

// File: rtl/pet2001ps2kbd.sv
// PET 2001 keyboard matrix fed from PS/2: scan-code decoder,
// 10x8 active-low key matrix and PIA1 port B read mux.
module pet2001ps2kbd
  import pet2001ps2kbd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] keyrow,
  output logic [7:0] keyin,
  output logic       kbd_reset,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_bv;
  logic       w_ext;
  logic       w_brk;
  key_t       w_key;
  dec_st_e    r_st;
  dec_st_e    w_st_nx;
  logic [2:0] r_skip;
  logic [2:0] w_skip_nx;
  logic       w_clr;
  logic       w_set;
  logic       w_f12;
  logic       r_kbd;

  logic [PET_ROWS-1:0][PET_COLS-1:0] r_mat;

  pet2001ps2kbd_rx #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (w_byte),
    .byte_valid(w_bv),
    .frame_err (frame_err)
  );

  assign w_ext = (r_st == ST_EXT) || (r_st == ST_EXT_BRK);
  assign w_brk = (r_st == ST_BRK) || (r_st == ST_EXT_BRK);
  assign w_key = key_lookup(w_ext, w_byte);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= ST_IDLE;
      r_skip <= '0;
    end else begin
      r_st   <= w_st_nx;
      r_skip <= w_skip_nx;
    end
  end

  always_comb begin
    w_st_nx   = r_st;
    w_skip_nx = r_skip;
    w_clr     = 1'b0;
    w_set     = 1'b0;
    w_f12     = 1'b0;
    if (w_bv) begin
      if (r_st == ST_SKIP) begin
        w_skip_nx = r_skip - 3'd1;
        if (r_skip == 3'd1) w_st_nx = ST_IDLE;
      end else if (is_ignored(w_byte)) begin
        w_st_nx = ST_IDLE;
      end else if (w_byte == PS2_E1) begin
        w_st_nx   = ST_SKIP;
        w_skip_nx = SKIP_LEN;
      end else if (r_st == ST_IDLE && w_byte == PS2_E0) begin
        w_st_nx = ST_EXT;
      end else if (r_st == ST_IDLE && w_byte == PS2_F0) begin
        w_st_nx = ST_BRK;
      end else if (r_st == ST_EXT && w_byte == PS2_F0) begin
        w_st_nx = ST_EXT_BRK;
      end else begin
        w_st_nx = ST_IDLE;
        w_clr   = w_key.hit & ~w_brk;
        w_set   = w_key.hit & w_brk;
        w_f12   = ~w_ext & ~w_brk & (w_byte == PS2_F12);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mat <= '1;
      r_kbd <= 1'b0;
    end else begin
      r_kbd <= w_f12;
      if (w_clr) r_mat[w_key.row][w_key.col] <= 1'b0;
      else if (w_set) r_mat[w_key.row][w_key.col] <= 1'b1;
    end
  end

  always_comb begin
    keyin = 8'hFF;
    if (keyrow < 4'(PET_ROWS)) keyin = r_mat[keyrow];
  end

  assign kbd_reset = r_kbd;

endmodule
